// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter + scoreboard: round-robin share of the single RF write port between ALU (A) and load return (B).
// Latency: handshake in N drives rf_we in N+1; ready/stall/operands are combinational. Optional forwarding: REGFILE_WB_BYPASS_EN.
// Backpressure: only the granted requester sees ready; issue holds while hazard_stall is high; no internal buffering.
module regfile_wb_arbiter #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int NUM_REGISTERS  = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      a_valid,
  output logic                      a_ready,
  input  logic [REG_ADDR_WIDTH-1:0] a_rd,
  input  logic [DATA_WIDTH-1:0]     a_data,
  input  logic                      b_valid,
  output logic                      b_ready,
  input  logic [REG_ADDR_WIDTH-1:0] b_rd,
  input  logic [DATA_WIDTH-1:0]     b_data,
  input  logic                      claim_valid,
  input  logic [REG_ADDR_WIDTH-1:0] claim_rd,
  input  logic [REG_ADDR_WIDTH-1:0] rs1_addr,
  input  logic [REG_ADDR_WIDTH-1:0] rs2_addr,
  input  logic [DATA_WIDTH-1:0]     rs1_rf,
  input  logic [DATA_WIDTH-1:0]     rs2_rf,
  output logic [DATA_WIDTH-1:0]     rs1_data,
  output logic [DATA_WIDTH-1:0]     rs2_data,
  output logic                      hazard_stall,
  output logic                      rf_we,
  output logic [REG_ADDR_WIDTH-1:0] rf_waddr,
  output logic [DATA_WIDTH-1:0]     rf_wdata,
  output logic                      sb_err
);

  typedef struct packed {
    logic [REG_ADDR_WIDTH-1:0] rd;
    logic [DATA_WIDTH-1:0]     data;
  } wb_t;

  typedef enum logic {
    SRC_A = 1'b0,
    SRC_B = 1'b1
  } src_e;

  src_e                     rr_last;
  logic                     grant_a;
  logic                     grant_b;
  wb_t                      wb_win;
  logic [NUM_REGISTERS-1:0] pending;
  logic [NUM_REGISTERS-1:0] pending_nxt;
  logic                     rs1_byp;
  logic                     rs2_byp;
  logic                     rs1_haz;
  logic                     rs2_haz;
  logic                     waw_haz;
  logic                     claim_take;

  // Ready is gated by reset so nothing is accepted while the block is held in reset.
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (rst_n) begin
      if (a_valid && b_valid) begin
        grant_a = (rr_last == SRC_B);
        grant_b = (rr_last == SRC_A);
      end else begin
        grant_a = a_valid;
        grant_b = b_valid;
      end
    end
  end

  assign a_ready = grant_a;
  assign b_ready = grant_b;
  assign wb_win  = grant_a ? wb_t'{rd: a_rd, data: a_data} : wb_t'{rd: b_rd, data: b_data};

`ifdef REGFILE_WB_BYPASS_EN
  assign rs1_byp = rf_we && (rf_waddr == rs1_addr) && (rs1_addr != '0);
  assign rs2_byp = rf_we && (rf_waddr == rs2_addr) && (rs2_addr != '0);
`else
  assign rs1_byp = 1'b0;
  assign rs2_byp = 1'b0;
`endif

  // pending[0] is never set, so x0 sources and destinations never stall.
  assign rs1_haz      = pending[rs1_addr] && !rs1_byp;
  assign rs2_haz      = pending[rs2_addr] && !rs2_byp;
  assign waw_haz      = pending[claim_rd];
  assign hazard_stall = claim_valid && (rs1_haz || rs2_haz || waw_haz);
  assign claim_take   = claim_valid && !hazard_stall;

  assign rs1_data = rs1_byp ? rf_wdata : rs1_rf;
  assign rs2_data = rs2_byp ? rf_wdata : rs2_rf;

  // Claim applied after retire so a same-cycle set on the retiring register wins.
  always_comb begin
    pending_nxt = pending;
    if (rf_we) begin
      pending_nxt[rf_waddr] = 1'b0;
    end
    if (claim_take) begin
      pending_nxt[claim_rd] = 1'b1;
    end
    pending_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending  <= '0;
      rr_last  <= SRC_A;
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
      sb_err   <= 1'b0;
    end else begin
      pending <= pending_nxt;
      if (rf_we && !pending[rf_waddr]) begin
        sb_err <= 1'b1;
      end
      if (grant_a || grant_b) begin
        rr_last  <= grant_a ? SRC_A : SRC_B;
        rf_we    <= (wb_win.rd != '0);
        rf_waddr <= wb_win.rd;
        rf_wdata <= wb_win.data;
      end else begin
        rf_we <= 1'b0;
      end
    end
  end

  a_one_ready: assert property (@(posedge clk) disable iff (!rst_n) !(a_ready && b_ready));
  a_x0_clean:  assert property (@(posedge clk) disable iff (!rst_n) !pending[0]);

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed + randomized bench for regfile_wb_arbiter against a behavioural scoreboard model.
module tb_regfile_wb_arbiter;

`ifdef REGFILE_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        a_valid, b_valid, claim_valid;
  logic        a_ready, b_ready;
  logic [4:0]  a_rd, b_rd, claim_rd, rs1_addr, rs2_addr;
  logic [31:0] a_data, b_data, rs1_rf, rs2_rf;
  logic [31:0] rs1_data, rs2_data;
  logic        hazard_stall, rf_we, sb_err;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  int errors = 0;
  int checks = 0;

  // Reference model state
  bit          m_pend [32];
  bit          m_last_b;
  bit          m_we;
  logic [4:0]  m_waddr;
  logic [31:0] m_wdata;
  bit          m_err;
  bit          last_ga, last_gb, last_st;

  // Values sampled during the most recent step
  logic        s_ar, s_br, s_st, s_we, s_err;
  logic [4:0]  s_waddr;
  logic [31:0] s_rs1;

  int issued;

  regfile_wb_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_ready(a_ready), .a_rd(a_rd), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_rd(b_rd), .b_data(b_data),
    .claim_valid(claim_valid), .claim_rd(claim_rd),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_rf(rs1_rf), .rs2_rf(rs2_rf),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .hazard_stall(hazard_stall),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .sb_err(sb_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_pend[i] = 1'b0;
    m_last_b = 1'b0;
    m_we     = 1'b0;
    m_waddr  = '0;
    m_wdata  = '0;
    m_err    = 1'b0;
    last_ga  = 1'b0;
    last_gb  = 1'b0;
    last_st  = 1'b0;
  endtask

  // Called at posedge+1; drops all requests, pulses reset for two edges.
  task automatic do_reset();
    rst_n       = 1'b0;
    a_valid     = 1'b0;
    b_valid     = 1'b0;
    claim_valid = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // One clock: check outputs at negedge against the model, advance the model at posedge.
  task automatic step(input string tag);
    bit ga, gb, byp1, byp2, st;
    logic [31:0] e1, e2;
    @(negedge clk);
    if (a_valid && b_valid) begin
      ga = m_last_b;
      gb = !m_last_b;
    end else begin
      ga = a_valid;
      gb = b_valid;
    end
    byp1 = BYP && m_we && (m_waddr == rs1_addr) && (rs1_addr != 0);
    byp2 = BYP && m_we && (m_waddr == rs2_addr) && (rs2_addr != 0);
    st = claim_valid && ((m_pend[rs1_addr] && !byp1) || (m_pend[rs2_addr] && !byp2) || m_pend[claim_rd]);
    e1 = byp1 ? m_wdata : rs1_rf;
    e2 = byp2 ? m_wdata : rs2_rf;
    s_ar = a_ready; s_br = b_ready; s_st = hazard_stall; s_we = rf_we;
    s_err = sb_err; s_waddr = rf_waddr; s_rs1 = rs1_data;
    chk({tag, ".a_ready"}, 32'(a_ready), 32'(ga));
    chk({tag, ".b_ready"}, 32'(b_ready), 32'(gb));
    chk({tag, ".hazard_stall"}, 32'(hazard_stall), 32'(st));
    chk({tag, ".rf_we"}, 32'(rf_we), 32'(m_we));
    chk({tag, ".rf_waddr"}, 32'(rf_waddr), 32'(m_waddr));
    chk({tag, ".rf_wdata"}, rf_wdata, m_wdata);
    chk({tag, ".sb_err"}, 32'(sb_err), 32'(m_err));
    chk({tag, ".rs1_data"}, rs1_data, e1);
    chk({tag, ".rs2_data"}, rs2_data, e2);
    last_ga = ga; last_gb = gb; last_st = st;
    @(posedge clk);
    if (m_we) begin
      if (!m_pend[m_waddr]) m_err = 1'b1;
      m_pend[m_waddr] = 1'b0;
    end
    if (claim_valid && !st && claim_rd != 0) m_pend[claim_rd] = 1'b1;
    if (ga) begin
      m_we = (a_rd != 0); m_waddr = a_rd; m_wdata = a_data; m_last_b = 1'b0;
    end else if (gb) begin
      m_we = (b_rd != 0); m_waddr = b_rd; m_wdata = b_data; m_last_b = 1'b1;
    end else begin
      m_we = 1'b0;
    end
    #1;
  endtask

  initial begin
    rst_n = 1'b0; a_valid = 1'b1; b_valid = 1'b0; claim_valid = 1'b0;
    a_rd = 5'd3; a_data = 32'h0000_0333; b_rd = '0; b_data = '0;
    claim_rd = '0; rs1_addr = '0; rs2_addr = '0; rs1_rf = '0; rs2_rf = '0;
    model_reset();

    // Reset: held request is not acknowledged, all outputs zero
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst.a_ready", 32'(a_ready), 32'd0);
    chk("rst.b_ready", 32'(b_ready), 32'd0);
    chk("rst.rf_we", 32'(rf_we), 32'd0);
    chk("rst.rf_waddr", 32'(rf_waddr), 32'd0);
    chk("rst.rf_wdata", rf_wdata, 32'd0);
    chk("rst.sb_err", 32'(sb_err), 32'd0);
    chk("rst.hazard_stall", 32'(hazard_stall), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    claim_valid = 1'b1; claim_rd = 5'd3;
    step("rel1");
    chk("rel1.grant_a", 32'(s_ar), 32'd1);
    chk("rel1.we_low", 32'(s_we), 32'd0);
    a_valid = 1'b0; claim_valid = 1'b0;
    step("rel2");
    chk("rel2.we", 32'(s_we), 32'd1);
    chk("rel2.waddr", 32'(s_waddr), 32'd3);
    chk("rel2.sb_err", 32'(s_err), 32'd0);

    // Tie: B first, then alternate
    do_reset();
    a_valid = 1'b1; a_rd = 5'd5; a_data = 32'h0000_0555;
    b_valid = 1'b1; b_rd = 5'd6; b_data = 32'h0000_0666;
    for (int i = 0; i < 5; i++) begin
      if (i == 4) begin a_valid = 1'b0; b_valid = 1'b0; end
      step("tie");
      if (i < 4) chk("tie.grant_b", 32'(s_br), 32'((i % 2) == 0));
      if (i >= 1) chk("tie.waddr_seq", 32'(s_waddr), ((i % 2) == 1) ? 32'd6 : 32'd5);
    end

    // Load-use on x10
    do_reset();
    claim_valid = 1'b1; claim_rd = 5'd10; rs1_addr = 5'd0; rs2_addr = 5'd0;
    step("lu0");
    chk("lu0.claim_ok", 32'(s_st), 32'd0);
    claim_rd = 5'd11; rs1_addr = 5'd10; rs1_rf = 32'h0BAD_F00D;
    b_valid = 1'b1; b_rd = 5'd10; b_data = 32'hDEAD_BEEF;
    issued = -1;
    for (int i = 0; i < 6 && issued < 0; i++) begin
      step("lu");
      if (i == 0) begin
        chk("lu.b_ready", 32'(s_br), 32'd1);
        chk("lu.stall_n", 32'(s_st), 32'd1);
        b_valid = 1'b0;
      end
      if (i == 1) begin
        chk("lu.rs1_n1", s_rs1, BYP ? 32'hDEAD_BEEF : 32'h0BAD_F00D);
        rs1_rf = 32'hDEAD_BEEF;
      end
      if (!last_st) issued = i;
    end
    claim_valid = 1'b0;
    chk("lu.issue_cycle", 32'(issued), BYP ? 32'd1 : 32'd2);
    chk("lu.issue_rs1", s_rs1, 32'hDEAD_BEEF);

    // Write-after-write on x7
    rs1_addr = 5'd0; rs2_addr = 5'd0;
    claim_valid = 1'b1; claim_rd = 5'd7;
    step("waw1");
    chk("waw1.stall", 32'(s_st), 32'd0);
    step("waw2");
    chk("waw2.stall", 32'(s_st), 32'd1);
    a_valid = 1'b1; a_rd = 5'd7; a_data = 32'h0000_0777;
    step("waw3");
    chk("waw3.stall", 32'(s_st), 32'd1);
    chk("waw3.a_ready", 32'(s_ar), 32'd1);
    a_valid = 1'b0;
    step("waw4");
    chk("waw4.stall", 32'(s_st), 32'd1);
    chk("waw4.waddr", 32'(s_waddr), 32'd7);
    step("waw5");
    chk("waw5.stall", 32'(s_st), 32'd0);
    claim_valid = 1'b0;

    // x0 write and x0 sources
    do_reset();
    a_valid = 1'b1; a_rd = 5'd0; a_data = 32'h0000_1234;
    step("x0a");
    chk("x0a.a_ready", 32'(s_ar), 32'd1);
    a_valid = 1'b0;
    claim_valid = 1'b1; claim_rd = 5'd0; rs1_addr = 5'd0; rs2_addr = 5'd0;
    step("x0b");
    chk("x0b.we", 32'(s_we), 32'd0);
    chk("x0b.stall", 32'(s_st), 32'd0);
    chk("x0b.sb_err", 32'(s_err), 32'd0);
    claim_valid = 1'b0;

    // Randomized traffic
    do_reset();
    for (int n = 0; n < 400; n++) begin
      if (!a_valid || last_ga) begin
        a_valid = ($urandom_range(0, 9) < 6); a_rd = 5'($urandom_range(0, 7)); a_data = $urandom;
      end
      if (!b_valid || last_gb) begin
        b_valid = ($urandom_range(0, 9) < 6); b_rd = 5'($urandom_range(0, 7)); b_data = $urandom;
      end
      claim_valid = ($urandom_range(0, 1) == 1);
      claim_rd = 5'($urandom_range(0, 7));
      rs1_addr = 5'($urandom_range(0, 7));
      rs2_addr = 5'($urandom_range(0, 7));
      rs1_rf = $urandom; rs2_rf = $urandom;
      step("rnd");
    end

    // Scoreboard error: unclaimed write to x3, sticky until reset
    do_reset();
    claim_valid = 1'b0; rs1_addr = 5'd0; rs2_addr = 5'd0;
    a_valid = 1'b1; a_rd = 5'd3; a_data = 32'h0000_0033;
    step("err1");
    chk("err1.a_ready", 32'(s_ar), 32'd1);
    a_valid = 1'b0;
    step("err2");
    chk("err2.we", 32'(s_we), 32'd1);
    chk("err2.sb_err", 32'(s_err), 32'd0);
    step("err3");
    chk("err3.sb_err", 32'(s_err), 32'd1);
    step("err4");
    chk("err4.sb_err", 32'(s_err), 32'd1);
    // Reset right after a handshake drops the registered write
    a_valid = 1'b1; a_rd = 5'd9; a_data = 32'h0000_0999;
    step("err5");
    do_reset();
    step("post");
    chk("post.we", 32'(s_we), 32'd0);
    chk("post.sb_err", 32'(s_err), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
